// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue and result-capture stage around a combinational 32-bit ALU.
// A small operand FIFO decouples the producer from the ALU. Each result, with its flags, is
// captured into a holding register that has its own valid/ready handshake. Reserved opcodes
// are flagged on the result side.
// Optional feature: define ALU_ISSUE_STATS_EN to add the stat_ops / stat_ovf issue counters.
module alu_issue_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    // producer side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [3:0]       in_op,
    // ALU side
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_equal,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    // consumer side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_equal,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [15:0]      stat_ovf
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

    localparam logic [3:0] OpAnd = 4'd0;
    localparam logic [3:0] OpOr  = 4'd1;
    localparam logic [3:0] OpXor = 4'd2;
    localparam logic [3:0] OpNor = 4'd3;
    localparam logic [3:0] OpAdd = 4'd5;
    localparam logic [3:0] OpSub = 4'd6;
    localparam logic [3:0] OpSlt = 4'd7;
    localparam logic [3:0] OpSrl = 4'd8;
    localparam logic [3:0] OpSll = 4'd9;
    localparam logic [3:0] OpSra = 4'd10;

    // Opcodes 4 and 11-15 are reserved.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OpAnd, OpOr, OpXor, OpNor,
            OpAdd, OpSub, OpSlt,
            OpSrl, OpSll, OpSra: legal = 1'b1;
            default:             legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Only arithmetic ops have a meaningful overflow; the ALU's flag is ignored otherwise.
    function automatic logic op_has_overflow(input logic [3:0] op);
        return (op == OpAdd) || (op == OpSub);
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + PtrW'(1);
    endfunction

    // ------------------------------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------------------------------
    logic [WIDTH-1:0] x_mem_q  [DEPTH];
    logic [WIDTH-1:0] y_mem_q  [DEPTH];
    logic [3:0]       op_mem_q [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic fifo_empty;
    logic push;
    logic issue;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_z_q, out_z_d;
    logic             out_equal_q, out_equal_d;
    logic             out_overflow_q, out_overflow_d;
    logic             out_zero_q, out_zero_d;
    logic             out_illegal_q, out_illegal_d;

    logic head_legal;
    logic head_ovf_en;

    assign fifo_empty = (count_q == '0);
    // in_ready looks only at the occupancy, never at out_ready.
    assign in_ready   = (count_q != CntFull);
    assign push       = in_valid & in_ready;
    assign issue      = ~fifo_empty & (~out_valid_q | out_ready);

    // Operand storage; data needs no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            x_mem_q[wr_ptr_q]  <= in_x;
            y_mem_q[wr_ptr_q]  <= in_y;
            op_mem_q[wr_ptr_q] <= in_op;
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (issue) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !issue) begin
            count_d = count_q + CntW'(1);
        end else if (!push && issue) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // ALU drive: head entry, or all zeros when the FIFO is empty
    // ------------------------------------------------------------------------------------------
    // Reserved opcodes are still driven raw; masking happens at capture.
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_op = '0;
        if (!fifo_empty) begin
            alu_x  = x_mem_q[rd_ptr_q];
            alu_y  = y_mem_q[rd_ptr_q];
            alu_op = op_mem_q[rd_ptr_q];
        end
    end

    assign head_legal  = op_is_legal(alu_op);
    assign head_ovf_en = op_has_overflow(alu_op);

    // ------------------------------------------------------------------------------------------
    // Result holding register
    // ------------------------------------------------------------------------------------------
    // Capture on issue; drop valid on a plain consume; otherwise hold everything.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_z_d        = out_z_q;
        out_equal_d    = out_equal_q;
        out_overflow_d = out_overflow_q;
        out_zero_d     = out_zero_q;
        out_illegal_d  = out_illegal_q;
        if (issue) begin
            out_valid_d = 1'b1;
            if (head_legal) begin
                out_z_d        = alu_z;
                out_equal_d    = alu_equal;
                out_overflow_d = head_ovf_en & alu_overflow;
                out_zero_d     = alu_zero;
                out_illegal_d  = 1'b0;
            end else begin
                out_z_d        = '0;
                out_equal_d    = 1'b0;
                out_overflow_d = 1'b0;
                out_zero_d     = 1'b0;
                out_illegal_d  = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_z_q        <= '0;
            out_equal_q    <= 1'b0;
            out_overflow_q <= 1'b0;
            out_zero_q     <= 1'b0;
            out_illegal_q  <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_z_q        <= out_z_d;
            out_equal_q    <= out_equal_d;
            out_overflow_q <= out_overflow_d;
            out_zero_q     <= out_zero_d;
            out_illegal_q  <= out_illegal_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_z        = out_z_q;
    assign out_equal    = out_equal_q;
    assign out_overflow = out_overflow_q;
    assign out_zero     = out_zero_q;
    assign out_illegal  = out_illegal_q;

`ifdef ALU_ISSUE_STATS_EN
    // ------------------------------------------------------------------------------------------
    // Saturating issue statistics
    // ------------------------------------------------------------------------------------------
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_ovf_q, stat_ovf_d;

    // Count issues, and issues that load a set overflow flag; both stick at all-ones.
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_ovf_d = stat_ovf_q;
        if (issue && (stat_ops_q != '1)) begin
            stat_ops_d = stat_ops_q + 32'd1;
        end
        if (issue && out_overflow_d && (stat_ovf_q != '1)) begin
            stat_ovf_d = stat_ovf_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_ovf_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_ovf_q <= stat_ovf_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: behavioural ALU plus a transaction-level reference model.
module tb_alu_issue_stage;

    localparam int W = 32;
    localparam int D = 2;

    typedef struct packed {
        logic [31:0] z;
        logic        eq;
        logic        ovf;
        logic        zr;
        logic        ill;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic [3:0]    in_op = '0;
    logic [W-1:0]  alu_x, alu_y, alu_z;
    logic [3:0]    alu_op;
    logic          alu_equal, alu_overflow, alu_zero;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_z;
    logic          out_equal, out_overflow, out_zero, out_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0]   stat_ops;
    logic [15:0]   stat_ovf;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    logic force_ovf = 1'b0;
    res_t exp_q[$];
    logic [3:0] legal_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_op        (in_op),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_op       (alu_op),
        .alu_z        (alu_z),
        .alu_equal    (alu_equal),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_equal    (out_equal),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_illegal  (out_illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_ovf     (stat_ovf)
`endif
    );

    // Behavioural ALU. Non-arithmetic ops report a junk overflow so masking gets exercised,
    // and reserved ops produce x^y so flag masking on illegal ops is visible.
    longint  alu_sum;
    logic [31:0] alu_t;
    logic    alu_v;
    always_comb begin
        alu_sum = 0;
        alu_t   = alu_x ^ alu_y;
        alu_v   = force_ovf | (^alu_x);
        case (alu_op)
            4'd0: alu_t = alu_x & alu_y;
            4'd1: alu_t = alu_x | alu_y;
            4'd2: alu_t = alu_x ^ alu_y;
            4'd3: alu_t = ~(alu_x | alu_y);
            4'd5: begin
                alu_t   = alu_x + alu_y;
                alu_sum = longint'($signed(alu_x)) + longint'($signed(alu_y));
                alu_v   = (alu_sum > 64'sd2147483647) || (alu_sum < -64'sd2147483648);
            end
            4'd6: begin
                alu_t   = alu_x - alu_y;
                alu_sum = longint'($signed(alu_x)) - longint'($signed(alu_y));
                alu_v   = (alu_sum > 64'sd2147483647) || (alu_sum < -64'sd2147483648);
            end
            4'd7:  alu_t = ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
            4'd8:  alu_t = alu_x >> alu_y[4:0];
            4'd9:  alu_t = alu_x << alu_y[4:0];
            4'd10: alu_t = $unsigned($signed(alu_x) >>> alu_y[4:0]);
            default: ;
        endcase
        alu_z        = alu_t;
        alu_equal    = (alu_x == alu_y);
        alu_zero     = (alu_t == '0);
        alu_overflow = alu_v;
    end

    // Expected stage result for one accepted operation, from the opcode rules.
    function automatic res_t ref_res(input logic [31:0] x, input logic [31:0] y,
                                     input logic [3:0] op);
        res_t        r;
        logic [31:0] z;
        logic        v;
        logic [4:0]  s;
        s = y[4:0];
        v = 1'b0;
        z = '0;
        r = '0;
        case (op)
            4'd0: z = x & y;
            4'd1: z = x | y;
            4'd2: z = x ^ y;
            4'd3: z = ~(x | y);
            4'd5: begin z = x + y; v = (x[31] == y[31]) && (z[31] != x[31]); end
            4'd6: begin z = x - y; v = (x[31] != y[31]) && (z[31] != x[31]); end
            4'd7: z = (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, (x < y)};
            4'd8: z = x >> s;
            4'd9: z = x << s;
            4'd10: z = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            default: begin
                r.ill = 1'b1;
                return r;
            end
        endcase
        r.z   = z;
        r.eq  = (x == y);
        r.ovf = v;
        r.zr  = (z == 32'd0);
        return r;
    endfunction

    function automatic res_t cur_out();
        return {out_z, out_equal, out_overflow, out_zero, out_illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        force_ovf = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        exp_q.delete();
    endtask

    // Single operation: accept on one edge, issue on the next.
    task automatic send_one(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_op    = op;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({out_valid, cur_out()} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, cur_out()});
        end
        n_cmp++;
        if ({alu_x, alu_y, alu_op} !== '0) begin
            n_bad++;
            $display("FAIL reset_alu_drive: got %h expected 0", {alu_x, alu_y, alu_op});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add_ovf();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 32'h7FFF_FFFF;
        in_y      = 32'h0000_0001;
        in_op     = 4'd5;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_not_early: got out_valid=%b expected 0", out_valid);
        end
        n_cmp++;
        if ({alu_x, alu_y, alu_op} !== {32'h7FFF_FFFF, 32'h1, 4'd5}) begin
            n_bad++;
            $display("FAIL add_alu_drive: got %h expected %h", {alu_x, alu_y, alu_op},
                     {32'h7FFF_FFFF, 32'h1, 4'd5});
        end
        step();
        n_cmp++;
        if ({out_valid, cur_out()} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_result: got %h expected %h", {out_valid, cur_out()},
                     {1'b1, 32'h8000_0000, 4'b0100});
        end
        step();
        n_cmp++;
        if ({out_valid, out_z} !== {1'b0, 32'h8000_0000}) begin
            n_bad++;
            $display("FAIL consume_keeps_data: got %h expected %h", {out_valid, out_z},
                     {1'b0, 32'h8000_0000});
        end
    endtask

    task automatic test_sub_and();
        out_ready = 1'b1;
        send_one(32'h1234_5678, 32'h1234_5678, 4'd6);
        n_cmp++;
        if ({out_valid, cur_out()} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_equal: got %h expected %h", {out_valid, cur_out()},
                     {1'b1, 32'h0, 4'b1010});
        end
        force_ovf = 1'b1;
        send_one(32'hFFFF_FFFF, 32'h0, 4'd0);
        n_cmp++;
        if ({out_valid, cur_out()} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL and_ovf_masked: got %h expected %h", {out_valid, cur_out()},
                     {1'b1, 32'h0, 4'b0010});
        end
        force_ovf = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        res_t e [3];
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = $urandom;
            in_y     = $urandom;
            in_op    = legal_ops[$urandom_range(0, 9)];
            e[i]     = ref_res(in_x, in_y, in_op);
            step();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_full: got in_ready=%b expected 0", in_ready);
        end
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if ({out_valid, cur_out()} !== {1'b1, e[0]}) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: got %h expected %h", c,
                         {out_valid, cur_out()}, {1'b1, e[0]});
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({out_valid, cur_out()} !== {1'b1, e[i]}) begin
                n_bad++;
                $display("FAIL bp_drain_%0d: got %h expected %h", i,
                         {out_valid, cur_out()}, {1'b1, e[i]});
            end
            step();
        end
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_empty: got valid/ready %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        out_ready = 1'b1;
        force_ovf = 1'b1;
        v = $urandom;
        send_one(v, v, 4'd4);
        n_cmp++;
        if ({out_valid, cur_out()} !== {1'b1, 32'h0, 4'b0001}) begin
            n_bad++;
            $display("FAIL illegal_op4: got %h expected %h", {out_valid, cur_out()},
                     {1'b1, 32'h0, 4'b0001});
        end
        send_one($urandom, $urandom, 4'd12);
        n_cmp++;
        if ({out_valid, cur_out()} !== {1'b1, 32'h0, 4'b0001}) begin
            n_bad++;
            $display("FAIL illegal_op12: got %h expected %h", {out_valid, cur_out()},
                     {1'b1, 32'h0, 4'b0001});
        end
        send_one(32'hF0F0_F0F0, 32'hFFFF_0000, 4'd2);
        n_cmp++;
        if ({out_valid, cur_out()} !== {1'b1, 32'h0F0F_F0F0, 4'b0000}) begin
            n_bad++;
            $display("FAIL legal_after_illegal: got %h expected %h", {out_valid, cur_out()},
                     {1'b1, 32'h0F0F_F0F0, 4'b0000});
        end
        force_ovf = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got = 0;
        int   bubbles = 0;
        logic seen = 1'b0;
        res_t e;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 16; c++) begin
            if (sent < 16) begin
                in_valid = 1'b1;
                in_x     = $urandom;
                in_y     = $urandom;
                in_op    = 4'($urandom_range(0, 15));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                seen = 1'b1;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (cur_out() !== e) begin
                    n_bad++;
                    $display("FAIL b2b_result_%0d: got %h expected %h", got, cur_out(), e);
                end
                got++;
            end else if (seen) begin
                bubbles++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_res(in_x, in_y, in_op));
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got !== 16) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results expected 16", got);
        end
        n_cmp++;
        if (bubbles !== 0) begin
            n_bad++;
            $display("FAIL b2b_bubbles: got %0d expected 0", bubbles);
        end
    endtask

    task automatic test_random();
        res_t e;
        int   drained = 0;
        exp_q.delete();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_x      = $urandom;
            in_y      = $urandom;
            in_op     = 4'($urandom_range(0, 15));
            #1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (cur_out() !== e) begin
                    n_bad++;
                    $display("FAIL rand_result cycle %0d: got %h expected %h", c, cur_out(), e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_res(in_x, in_y, in_op));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                n_cmp++;
                if (cur_out() !== e) begin
                    n_bad++;
                    $display("FAIL rand_drain: got %h expected %h", cur_out(), e);
                end
                drained++;
            end
            step();
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL rand_lost: got %0d results left expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_x     = $urandom;
            in_y     = $urandom;
            in_op    = 4'd5;
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_stream_valid: got %b expected 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, alu_x} !== {2'b01, 32'h0}) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", {out_valid, in_ready, alu_x},
                     {2'b01, 32'h0});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stale_after_reset cycle %0d: got %b expected 0", c, out_valid);
            end
        end
        exp_q.delete();
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_stats();
        do_reset();
        out_ready = 1'b1;
        send_one(32'h7FFF_FFFF, 32'h1, 4'd5);
        send_one(32'h8000_0000, 32'h8000_0000, 4'd5);
        send_one(32'hFFFF_FFFF, 32'h1234_5670, 4'd0);
        send_one(32'd5, 32'd3, 4'd6);
        send_one(32'h0F00_0000, 32'h1, 4'd1);
        n_cmp++;
        if ({stat_ops, stat_ovf} !== {32'd5, 16'd2}) begin
            n_bad++;
            $display("FAIL stats_count: got ops=%0d ovf=%0d expected 5/2", stat_ops, stat_ovf);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({stat_ops, stat_ovf} !== '0) begin
            n_bad++;
            $display("FAIL stats_reset: got ops=%0d ovf=%0d expected 0/0", stat_ops, stat_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_and();
        do_reset();
        test_backpressure();
        test_illegal();
        do_reset();
        test_back_to_back();
        do_reset();
        test_random();
        do_reset();
        test_reset_mid();
`ifdef ALU_ISSUE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
